p405s_icu_fill_seq: RTL and testbench

//  Instruction-cache line-fill sequencer; initiator side for ICU data registers such as dp_regICU.
//  - Takes an ICU miss and issues one PLB line-read request.
//  - Gathers returned words (critical word first, wrapping).
//  - Drives each word into the ICU datapath register via D/E1-style strobes.
//  - Flags the critical word for early fetch forwarding.

---
 rtl/p405s_icu_pkg.sv | 22 ++
 rtl/p405s_icu_fill_ctr.sv | 33 +++
 rtl/p405s_icu_fill_seq.sv | 154 +++++++++++++++
 tb/tb_p405s_icu_fill_seq.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/p405s_icu_pkg.sv
// Shared types and constants for the ICU line-fill sequencer.
// Optional parity checking of read beats is enabled by defining ICU_FILL_PARITY_EN.
package p405s_icu_pkg;

    localparam int ICU_LINE_WORDS = 8;
    localparam int ICU_IDX_W      = 3;

    typedef logic [ICU_IDX_W-1:0] icu_off_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FILL,
        DONE
    } icu_fill_state_e;

    // The data word and its parity bit together must hold an odd number of ones.
    function automatic logic odd_par_ok(input logic [31:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/p405s_icu_fill_ctr.sv
// Beat counter for one line fill.
// Also produces the wrapped line offset of the current beat (start offset + count).
module p405s_icu_fill_ctr #(
    parameter int IDX_W = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [IDX_W-1:0] start_off_i,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [IDX_W-1:0] count_o,
    output logic [IDX_W-1:0] offset_o
);

    logic [IDX_W-1:0] count_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the clock edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (inc_i) begin
            count_q <= count_q + 1'b1;
        end
    end

    // Adding at IDX_W bits gives the modulo-line wrap for free.
    assign count_o  = count_q;
    assign offset_o = start_off_i + count_q;

endmodule

// File: rtl/p405s_icu_fill_seq.sv
// ICU line-fill sequencer: one PLB line read per miss, wrap-order beats into the ICU data register.
// Define ICU_FILL_PARITY_EN to add the plbRdPar input and per-beat odd-parity checking.
module p405s_icu_fill_seq
    import p405s_icu_pkg::*;
#(
    parameter int LINE_WORDS = ICU_LINE_WORDS,
    parameter int IDX_W      = ICU_IDX_W
) (
    input  logic             CB,
    input  logic             RST,
    input  logic             missValid,
    input  logic [0:29]      missAddr,
    input  logic             cancel,
    output logic             plbReq,
    output logic [0:29]      plbAddr,
    input  logic             plbAck,
    input  logic             plbRdDAck,
    input  logic [0:31]      plbRdData,
`ifdef ICU_FILL_PARITY_EN
    input  logic             plbRdPar,
`endif
    output logic [0:31]      fillD,
    output logic             fillE1,
    output logic [0:IDX_W-1] fillIdx,
    output logic             critVal,
    output logic             lineDone,
    output logic             fillErr,
    output logic             busy
);

    localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(LINE_WORDS - 1);

    icu_fill_state_e  state_q, state_d;
    logic [0:29]      addr_q, addr_d;
    logic             cancelled_q, cancelled_d;
    logic             perr_q, perr_d;
    logic [0:31]      fill_data_q, fill_data_d;
    logic             fill_e1_q, fill_e1_d;
    logic [IDX_W-1:0] fill_idx_q, fill_idx_d;
    logic             crit_q, crit_d;
    logic             line_done_q, line_done_d;
    logic             fill_err_q, fill_err_d;

    logic             ctr_inc, ctr_clr, par_ok, kill;
    logic [IDX_W-1:0] beat_cnt, beat_off;

    p405s_icu_fill_ctr #(.IDX_W(IDX_W)) u_ctr (
        .clk_i       (CB),
        .rst_i       (RST),
        .start_off_i (addr_q[30-IDX_W:29]),
        .inc_i       (ctr_inc),
        .clr_i       (ctr_clr),
        .count_o     (beat_cnt),
        .offset_o    (beat_off)
    );

`ifdef ICU_FILL_PARITY_EN
    assign par_ok = odd_par_ok(plbRdData, plbRdPar);
`else
    assign par_ok = 1'b1;
`endif

    // A beat arriving together with cancel is already suppressed.
    assign kill = cancelled_q | cancel;

    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cancelled_d = cancelled_q;
        perr_d      = perr_q;
        fill_data_d = fill_data_q;
        fill_e1_d   = 1'b0;
        fill_idx_d  = fill_idx_q;
        crit_d      = 1'b0;
        line_done_d = 1'b0;
        fill_err_d  = 1'b0;
        ctr_inc     = 1'b0;
        ctr_clr     = 1'b0;

        case (state_q)
            IDLE: begin
                ctr_clr     = 1'b1;
                cancelled_d = 1'b0;
                perr_d      = 1'b0;
                if (missValid) begin
                    addr_d  = missAddr;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (cancel) cancelled_d = 1'b1;
                if (plbAck) state_d = FILL;
            end
            FILL: begin
                if (cancel) cancelled_d = 1'b1;
                if (plbRdDAck) begin
                    ctr_inc     = 1'b1;
                    fill_data_d = plbRdData;
                    fill_idx_d  = beat_off;
                    fill_e1_d   = ~kill;
                    crit_d      = (beat_cnt == '0) & ~kill & par_ok;
                    perr_d      = perr_q | ~par_ok;
                    if (beat_cnt == LAST_CNT) state_d = DONE;
                end
            end
            DONE: begin
                line_done_d = 1'b1;
                fill_err_d  = cancelled_q | perr_q;
                ctr_clr     = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CB or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            cancelled_q <= 1'b0;
            perr_q      <= 1'b0;
            fill_data_q <= '0;
            fill_e1_q   <= 1'b0;
            fill_idx_q  <= '0;
            crit_q      <= 1'b0;
            line_done_q <= 1'b0;
            fill_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cancelled_q <= cancelled_d;
            perr_q      <= perr_d;
            fill_data_q <= fill_data_d;
            fill_e1_q   <= fill_e1_d;
            fill_idx_q  <= fill_idx_d;
            crit_q      <= crit_d;
            line_done_q <= line_done_d;
            fill_err_q  <= fill_err_d;
        end
    end

    assign plbReq   = (state_q == REQ);
    assign plbAddr  = addr_q;
    assign fillD    = fill_data_q;
    assign fillE1   = fill_e1_q;
    assign fillIdx  = fill_idx_q;
    assign critVal  = crit_q;
    assign lineDone = line_done_q;
    assign fillErr  = fill_err_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_p405s_icu_fill_seq.sv
// Randomized self-checking bench for p405s_icu_fill_seq against a line-level fill model.
// Parity expectations follow ICU_FILL_PARITY_EN.
module tb_p405s_icu_fill_seq;
    import p405s_icu_pkg::*;

    localparam int LW = ICU_LINE_WORDS;
`ifdef ICU_FILL_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic                 CB = 1'b0;
    logic                 RST;
    logic                 missValid, cancel, plbAck, plbRdDAck, plbRdPar;
    logic [29:0]          missAddr, plbAddr;
    logic [31:0]          plbRdData, fillD;
    logic                 plbReq, fillE1, critVal, lineDone, fillErr, busy;
    logic [ICU_IDX_W-1:0] fillIdx;

    int total = 0;
    int bad   = 0;

    always #5 CB = ~CB;

    p405s_icu_fill_seq dut (
        .CB        (CB),
        .RST       (RST),
        .missValid (missValid),
        .missAddr  (missAddr),
        .cancel    (cancel),
        .plbReq    (plbReq),
        .plbAddr   (plbAddr),
        .plbAck    (plbAck),
        .plbRdDAck (plbRdDAck),
        .plbRdData (plbRdData),
`ifdef ICU_FILL_PARITY_EN
        .plbRdPar  (plbRdPar),
`endif
        .fillD     (fillD),
        .fillE1    (fillE1),
        .fillIdx   (fillIdx),
        .critVal   (critVal),
        .lineDone  (lineDone),
        .fillErr   (fillErr),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CB);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {plbReq, fillE1, critVal, lineDone, fillErr, busy}, '0);
        check({tag, "_dat"}, {plbAddr, fillD, fillIdx}, '0);
    endtask

    // One complete miss. cancel_beat/bad_beat < 0 mean "none".
    task automatic run_line(input logic [29:0] addr, input int ack_dly, input int gmin,
                            input int gmax, input int cancel_beat, input int bad_beat);
        icu_off_t    start_off;
        icu_off_t    exp_idx;
        logic [31:0] data;
        bit          killed, exp_err;
        start_off = addr[ICU_IDX_W-1:0];
        exp_err   = (cancel_beat >= 0) || (PAR_EN && bad_beat >= 0);

        missValid = 1'b1;
        missAddr  = addr;
        tick();
        check("req_busy", busy, 1'b1);
        check("req_addr", plbAddr, addr);
        for (int i = 0; i < ack_dly; i++) begin
            missAddr = $urandom;
            tick();
            check("req_hold", plbReq, 1'b1);
        end
        plbAck = 1'b1;
        tick();
        plbAck = 1'b0;
        check("req_drop", plbReq, 1'b0);
        check("addr_kept", plbAddr, addr);

        for (int b = 0; b < LW; b++) begin
            int gap = $urandom_range(gmax, gmin);
            for (int g = 0; g < gap; g++) begin
                tick();
                check("gap_e1", fillE1, 1'b0);
                check("gap_done", lineDone, 1'b0);
            end
            data      = $urandom;
            plbRdData = data;
            plbRdPar  = ~(^data) ^ (b == bad_beat);
            plbRdDAck = 1'b1;
            cancel    = (b == cancel_beat);
            tick();
            plbRdDAck = 1'b0;
            cancel    = 1'b0;
            killed    = (cancel_beat >= 0) && (b >= cancel_beat);
            exp_idx   = start_off + icu_off_t'(b);
            check("beat_e1", fillE1, !killed);
            if (!killed) begin
                check("beat_idx", fillIdx, exp_idx);
                check("beat_data", fillD, data);
            end
            check("beat_crit", critVal, (b == 0) && !killed && !(PAR_EN && b == bad_beat));
        end

        check("last_busy", busy, 1'b1);
        check("last_nodone", lineDone, 1'b0);
        tick();
        check("done", lineDone, 1'b1);
        check("done_err", fillErr, exp_err);
        check("done_idle", busy, 1'b0);
        check("done_e1", fillE1, 1'b0);
        missValid = 1'b0;
        tick();
        check("done_pulse", {lineDone, fillErr}, 2'b00);
        check("no_rereq", {busy, plbReq}, 2'b00);
    endtask

    initial begin
        RST = 1'b1;
        {missValid, cancel, plbAck, plbRdDAck, plbRdPar} = '0;
        missAddr  = '0;
        plbRdData = '0;
        repeat (2) @(posedge CB);
        #1;
        check_all_zero("reset");
        RST = 1'b0;
        tick();
        check_all_zero("post_reset");

        run_line(30'h100, 2, 0, 0, -1, -1);   // offset 0, back-to-back
        run_line(30'h105, 1, 0, 0, -1, -1);   // offset 5, wrapped order
        run_line(30'h2a3, 0, 1, 3, -1, -1);   // idle gaps between beats
        run_line(30'h0f0, 3, 0, 1, 2, -1);    // cancel with beat 2
        run_line(30'h311, 1, 0, 2, -1, 0);    // bad parity on beat 0

        // Asynchronous reset in the middle of a fill, with missValid held.
        missValid = 1'b1;
        missAddr  = 30'h1234;
        tick();
        plbAck = 1'b1;
        tick();
        plbAck = 1'b0;
        for (int b = 0; b < 4; b++) begin
            plbRdData = $urandom;
            plbRdPar  = ~(^plbRdData);
            plbRdDAck = 1'b1;
            tick();
        end
        plbRdData = $urandom;
        plbRdPar  = ~(^plbRdData);
        #2 RST = 1'b1;
        #1;
        check_all_zero("async_rst");
        missValid = 1'b0;
        plbRdDAck = 1'b0;
        @(negedge CB);
        RST = 1'b0;
        tick();
        check_all_zero("rst_idle");
        tick();
        check("rst_no_req", {busy, plbReq}, 2'b00);

        for (int i = 0; i < 8; i++) begin
            int cb = ($urandom_range(2, 0) == 0) ? int'($urandom_range(LW - 1, 0)) : -1;
            int pb = ($urandom_range(2, 0) == 0) ? int'($urandom_range(LW - 1, 0)) : -1;
            run_line(30'($urandom), $urandom_range(3, 0), 0, $urandom_range(3, 0), cb, pb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
